// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter
//   Round-robin arbiter sharing one internal register bus between NREQ
//   requesters. Each requester issues a single read or write over a
//   valid/ack handshake. The arbiter drives a one-cycle strobe, waits RD_LAT
//   cycles for read data, then pulses req_ack to the granted requester.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   req_valid/wr     per-requester request and direction (1 = write)
//   req_addr/wdata   flattened 32-bit fields, requester i at [32i+31:32i]
//   req_ack          one-cycle completion pulse to the granted requester
//   req_rdata        read data, valid in the ack cycle of a read, held after
//   grant_id         current or last granted requester
//   busy             high whenever the FSM is not idle
//   reg_addr/wdata   register bus address / write data (held between txns)
//   reg_wr/reg_rd    one-cycle strobes
//   reg_rdata        register bus read data
module reg_bus_arbiter #(
  parameter  int NREQ   = 2,
  parameter  int RD_LAT = 1,
  localparam int GW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_wr,
  input  logic [32*NREQ-1:0] req_addr,
  input  logic [32*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ack,
  output logic [31:0]        req_rdata,
  output logic [GW-1:0]      grant_id,
  output logic               busy,
  output logic [31:0]        reg_addr,
  output logic [31:0]        reg_wdata,
  output logic               reg_wr,
  output logic               reg_rd,
  input  logic [31:0]        reg_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_e;

  // WAIT is entered with RD_LAT-1 and leaves on zero, so it lasts RD_LAT cycles.
  localparam logic [2:0] CNT_INIT = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [GW-1:0]     last_q, last_d;
  logic [GW-1:0]     gid_q, gid_d;
  logic              is_wr_q, is_wr_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              busy_q, busy_d;

  // Round-robin pick: first valid requester after last_q, wrapping.
  logic              found;
  logic [GW-1:0]     pick;
  int                j;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    j     = 0;
    for (int s = 1; s <= NREQ; s++) begin
      j = (int'(last_q) + s) % NREQ;
      if (!found && req_valid[j]) begin
        found = 1'b1;
        pick  = GW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gid_d   = gid_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    ack_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gid_d   = pick;
          is_wr_d = req_wr[pick];
          addr_d  = req_addr[32*int'(pick) +: 32];
          wdata_d = req_wdata[32*int'(pick) +: 32];
          // Strobes are registered, so they are raised on the grant edge.
          wr_d    = req_wr[pick];
          rd_d    = !req_wr[pick];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (is_wr_q) begin
          state_d = ACK;
        end else if (RD_LAT == 0) begin
          rdata_d = reg_rdata;
          state_d = ACK;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          rdata_d = reg_rdata;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ACK: begin
        last_d  = gid_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Ack is registered: raise it on the edge that enters ACK.
    if (state_d == ACK) ack_d[gid_q] = 1'b1;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= GW'(NREQ - 1);
      gid_q   <= '0;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign req_ack   = ack_q;
  assign req_rdata = rdata_q;
  assign grant_id  = gid_q;
  assign busy      = busy_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr    = wr_q;
  assign reg_rd    = rd_q;

endmodule

// File: doc/reg_bus_arbiter.md
# reg_bus_arbiter

Round-robin arbiter that shares the single internal register bus (reg_addr / reg_wdata / reg_wr / reg_rd / reg_rdata) between NREQ independent requesters. Typical requesters are the AXI4-Lite bridge and on-chip engines that program or poll the same register file. Each requester issues one complete read or write at a time over a valid/ack handshake. The arbiter sequences the strobe and waits a fixed read latency for the register file.

## Interface
- NREQ, 2: number of requesters (2..8).
- RD_LAT, 1: cycles from the reg_rd strobe to valid reg_rdata (0..7).
- GW, derived: grant index width, max(1, clog2(NREQ)).
- clk  in  1  single clock for all logic.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  per-requester transaction request, held until ack.
- req_wr  in  NREQ  1 = write, 0 = read.
- req_addr  in  32*NREQ  flattened addresses; requester i occupies bits [32i+31:32i].
- req_wdata  in  32*NREQ  flattened write data, same layout.
- req_ack  out  NREQ  one-cycle completion pulse to the granted requester.
- req_rdata  out  32  read data, valid in the req_ack cycle of a read.
- grant_id  out  GW  index of the current or last granted requester.
- busy  out  1  high in every state except IDLE.
- reg_addr  out  32  register bus address.
- reg_wdata  out  32  register bus write data.
- reg_wr  out  1  one-cycle write strobe.
- reg_rd  out  1  one-cycle read strobe.
- reg_rdata  in  32  register bus read data.

## Operation
- All outputs are registered.
- Reset values: every output is 0; state = IDLE; last_grant = NREQ-1, so requester 0 has the highest priority first.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If any req_valid is high, select the first set bit searching from (last_grant+1) mod NREQ upward, with wrap-around.
  - Latch that requester's addr, wdata and wr; set grant_id; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - reg_addr and reg_wdata carry the latched values.
  - reg_wr = 1 for a write, or reg_rd = 1 for a read.
  - Write: go to ACK.
  - Read with RD_LAT = 0: capture reg_rdata into req_rdata in this cycle; go to ACK.
  - Read with RD_LAT > 0: load the counter with RD_LAT-1; go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter equals 0, capture reg_rdata into req_rdata and go to ACK.
  - WAIT therefore lasts exactly RD_LAT cycles.
- ACK (1 cycle):
  - req_ack[grant_id] = 1; all other ack bits stay 0.
  - last_grant <= grant_id; go to IDLE.
- req_rdata holds its value until the next read capture; writes do not modify it.
- reg_addr and reg_wdata hold their last values between transactions. reg_wr and reg_rd are high only in ISSUE.
- Request fields are sampled only in the IDLE grant cycle. Changes after the grant are ignored.
- A requester may withdraw req_valid before it is granted; no transaction results.
- Withdrawing req_valid after the grant does not abort the transaction; ack is still issued.
- A requester must drop req_valid, or present its next request, on the clock edge at which it sees req_ack. req_valid in the cycle after ACK is treated as a new request.
- rst asserted in any state:
  - Returns to IDLE on the next edge; the pending transaction is dropped with no ack.
  - All outputs go to 0 and last_grant goes to NREQ-1.
  - A strobe already issued is not retracted.

## Timing
- Request seen in IDLE at cycle 0:
  - Write: reg_wr at cycle 1, req_ack at cycle 2.
  - Read: reg_rd at cycle 1, reg_rdata sampled at cycle 1+RD_LAT, req_ack and req_rdata at cycle 2+RD_LAT.
- Minimum transaction spacing:
  - Writes: 3 cycles (IDLE, ISSUE, ACK).
  - Reads: 3+RD_LAT cycles.
- With all requesters continuously valid, grants rotate 0,1,..,NREQ-1,0. No requester waits more than NREQ-1 transactions.
- busy rises in the cycle after the request is accepted (ISSUE) and falls in the cycle after ACK.

## Test plan
- Reset: drive rst for 2 cycles with req_valid=all-ones. All outputs must read 0 during reset and in the first cycle after it; the first grant goes to requester 0.
- Single write: req 0, addr 0x0000_0010, wdata 0xDEAD_BEEF. reg_wr=1 with those values exactly one cycle later; req_ack=2'b01 the cycle after that; reg_rd never asserted.
- Read with RD_LAT=2: req 1 reads 0x0000_0020, and the register model returns 0x1234_5678 two cycles after reg_rd. req_ack=2'b10 arrives 4 cycles after acceptance with req_rdata=0x1234_5678; a preceding write leaves req_rdata unchanged.
- Read with RD_LAT=0: reg_rdata returns 0xA5A5_0001 combinationally in the reg_rd cycle. Ack arrives 2 cycles after acceptance with that data.
- Contention: both requesters continuously issue writes with distinct addresses. Grants alternate 0,1,0,1; acks are spaced 3 cycles apart; no ack is ever issued to a non-granted requester.
- Reset in WAIT (RD_LAT=4): assert rst in the second WAIT cycle. No req_ack is issued, the FSM returns to IDLE, and the next request from requester 1 alone completes normally.
